// File: rtl/fp_div_pkg.sv
// Shared types and constants for the single-precision divider.
package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    DIVIDE = 2'd2,
    ROUND  = 2'd3
  } state_t;

  localparam int          BIAS      = 127;
  localparam int          EXP_MAX   = 255;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam int          DIV_ITERS = 26;
  localparam int          LATENCY   = 28;

  // Bit positions inside flags = {invalid, div_by_zero, overflow, underflow}
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIV_ZERO  = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

endpackage

// File: rtl/fp_div_mant_iter.sv
// Restoring mantissa divider: one quotient bit per cycle for ITERS cycles.
// The first step compares the raw dividend against the divisor, so the MSB
// of the quotient is the integer bit of dividend/divisor (range 0.5 .. 2).
module fp_div_mant_iter
  import fp_div_pkg::*;
#(
  parameter int ITERS = DIV_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      dividend,
  input  logic [23:0]      divisor,
  output logic             done,
  output logic [ITERS-1:0] quotient,
  output logic             sticky
);

  localparam int            CW   = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  logic [25:0]      rem_q, rem_d;
  logic [23:0]      div_q, div_d;
  logic [ITERS-1:0] quot_q, quot_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [25:0]      div_ext;
  logic [25:0]      trial;
  logic             fits;

  // Load operands on start, otherwise do one compare/subtract/shift step.
  always_comb begin
    div_ext = {2'b00, div_q};
    fits    = (rem_q >= div_ext);
    trial   = rem_q - div_ext;
    rem_d   = rem_q;
    div_d   = div_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (start) begin
      rem_d  = {2'b00, dividend};
      div_d  = divisor;
      quot_d = '0;
      cnt_d  = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      rem_d  = (fits ? trial : rem_q) << 1;
      quot_d = {quot_q[ITERS-2:0], fits};
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        run_d = 1'b0;
      end
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      div_q  <= div_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

  // done is high during the final step; quotient/sticky are complete from the next cycle.
  assign done     = run_q && (cnt_q == LAST);
  assign quotient = quot_q;
  assign sticky   = |rem_q;

endmodule

// File: rtl/fp_div_32.sv
// IEEE-754 single-precision divider, fixed latency, round-to-nearest-even,
// denormals flushed to zero on input and output.
module fp_div_32
  import fp_div_pkg::*;
#(
  parameter int LATENCY = fp_div_pkg::LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        busy,
  output logic        done,
  output logic [31:0] m,
  output logic [3:0]  flags
);

  state_t             state_q, state_d;
  logic [31:0]        x_q, x_d, y_q, y_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               spec_q, spec_d;
  logic [31:0]        spec_m_q, spec_m_d;
  logic [3:0]         spec_flags_q, spec_flags_d;
  logic [31:0]        m_q, m_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [7:0]  ex_x, ex_y;
  logic        x_zero, x_inf, x_nan, y_zero, y_inf, y_nan;
  logic        res_sign;
  logic [31:0] inf_word, zero_word;
  logic        unp_spec;
  logic [31:0] unp_m;
  logic [3:0]  unp_flags;

  logic              iter_start, iter_done, iter_sticky;
  logic [DIV_ITERS-1:0] quot;

  logic              norm, guard, sticky_all, round_up;
  logic [23:0]       mant_pre;
  logic [24:0]       mant_sum;
  logic [22:0]       mant_fin;
  logic signed [9:0] e_norm, e_fin;
  logic [31:0]       rnd_m;
  logic [3:0]        rnd_flags;

  assign iter_start = (state_q == UNPACK);

  fp_div_mant_iter #(
    .ITERS(LATENCY - 2)
  ) u_iter (
    .clk     (clk),
    .reset   (reset),
    .start   (iter_start),
    .dividend({1'b1, x_q[22:0]}),
    .divisor ({1'b1, y_q[22:0]}),
    .done    (iter_done),
    .quotient(quot),
    .sticky  (iter_sticky)
  );

  // Classify captured operands and resolve special cases; denormals count as zero.
  always_comb begin
    ex_x      = x_q[30:23];
    ex_y      = y_q[30:23];
    x_zero    = (ex_x == 8'h00);
    y_zero    = (ex_y == 8'h00);
    x_inf     = (ex_x == 8'hFF) && (x_q[22:0] == 23'd0);
    y_inf     = (ex_y == 8'hFF) && (y_q[22:0] == 23'd0);
    x_nan     = (ex_x == 8'hFF) && (x_q[22:0] != 23'd0);
    y_nan     = (ex_y == 8'hFF) && (y_q[22:0] != 23'd0);
    res_sign  = x_q[31] ^ y_q[31];
    inf_word  = {res_sign, 8'(EXP_MAX), 23'd0};
    zero_word = {res_sign, 31'd0};
    unp_spec  = 1'b1;
    unp_m     = '0;
    unp_flags = '0;
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
      unp_m                   = QNAN;
      unp_flags[FLAG_INVALID] = 1'b1;
    end else if (x_inf) begin
      unp_m = inf_word;
    end else if (y_inf) begin
      unp_m = zero_word;
    end else if (y_zero) begin
      unp_m                    = inf_word;
      unp_flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (x_zero) begin
      unp_m = zero_word;
    end else begin
      unp_spec = 1'b0;
    end
  end

  // Normalize the 26-bit quotient, round to nearest even, then clamp the exponent.
  always_comb begin
    norm = quot[DIV_ITERS-1];
    if (norm) begin
      mant_pre   = quot[25:2];
      guard      = quot[1];
      sticky_all = quot[0] | iter_sticky;
      e_norm     = exp_q;
    end else begin
      mant_pre   = quot[24:1];
      guard      = quot[0];
      sticky_all = iter_sticky;
      e_norm     = exp_q - 10'sd1;
    end
    round_up = guard & (sticky_all | mant_pre[0]);
    mant_sum = {1'b0, mant_pre} + {24'd0, round_up};
    if (mant_sum[24]) begin
      mant_fin = mant_sum[23:1];
      e_fin    = e_norm + 10'sd1;
    end else begin
      mant_fin = mant_sum[22:0];
      e_fin    = e_norm;
    end
    rnd_flags = '0;
    if (e_fin >= $signed(10'(EXP_MAX))) begin
      rnd_m                    = {sign_q, 8'(EXP_MAX), 23'd0};
      rnd_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      rnd_m                     = {sign_q, 31'd0};
      rnd_flags[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      rnd_m = {sign_q, e_fin[7:0], mant_fin};
    end
  end

  // Next-state and output logic for the IDLE/UNPACK/DIVIDE/ROUND sequence.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    sign_d       = sign_q;
    exp_d        = exp_q;
    spec_d       = spec_q;
    spec_m_d     = spec_m_q;
    spec_flags_d = spec_flags_q;
    m_d          = m_q;
    flags_d      = flags_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d       = res_sign;
        exp_d        = $signed({2'b00, ex_x}) - $signed({2'b00, ex_y}) + $signed(10'(BIAS));
        spec_d       = unp_spec;
        spec_m_d     = unp_m;
        spec_flags_d = unp_flags;
        state_d      = DIVIDE;
      end
      DIVIDE: begin
        if (iter_done) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        m_d     = spec_q ? spec_m_q : rnd_m;
        flags_d = spec_q ? spec_flags_q : rnd_flags;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // All control, datapath and output registers; reset returns to an idle, cleared unit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      spec_q       <= 1'b0;
      spec_m_q     <= '0;
      spec_flags_q <= '0;
      m_q          <= '0;
      flags_q      <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sign_q       <= sign_d;
      exp_q        <= exp_d;
      spec_q       <= spec_d;
      spec_m_q     <= spec_m_d;
      spec_flags_q <= spec_flags_d;
      m_q          <= m_d;
      flags_q      <= flags_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign m     = m_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_fp_div_32.sv
// Self-checking bench for fp_div_32: directed corner cases plus random
// operands compared against an exact-rational division model.
module tb_fp_div_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] x, y;
  logic        busy, done;
  logic [31:0] m;
  logic [3:0]  flags;

  int checkCount;
  int errorCount;

  fp_div_32 dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .x    (x),
    .y    (y),
    .busy (busy),
    .done (done),
    .m    (m),
    .flags(flags)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference quotient from the exact ratio of the mantissas: round to nearest
  // even by comparing twice the remainder with the divisor. Returns {flags, m}.
  function automatic logic [35:0] refDiv(input logic [31:0] a, input logic [31:0] b);
    logic   s, aNan, bNan, aInf, bInf, aZero, bZero;
    int     ea, eb, e;
    longint ma, mb, num, q, r;
    s     = a[31] ^ b[31];
    ea    = int'(a[30:23]);
    eb    = int'(b[30:23]);
    aNan  = (ea == 255) && (a[22:0] != 0);
    bNan  = (eb == 255) && (b[22:0] != 0);
    aInf  = (ea == 255) && (a[22:0] == 0);
    bInf  = (eb == 255) && (b[22:0] == 0);
    aZero = (ea == 0);
    bZero = (eb == 0);
    if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) return {4'b1000, 32'h7FC00000};
    if (aInf)  return {4'b0000, s, 8'hFF, 23'd0};
    if (bInf)  return {4'b0000, s, 31'd0};
    if (bZero) return {4'b0100, s, 8'hFF, 23'd0};
    if (aZero) return {4'b0000, s, 31'd0};
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    e  = ea - eb + 127;
    if (ma >= mb) begin
      num = ma << 23;
    end else begin
      num = ma << 24;
      e   = e - 1;
    end
    q = num / mb;
    r = num % mb;
    if ((2 * r > mb) || ((2 * r == mb) && (q % 2 == 1))) q = q + 1;
    if (q == (64'sd1 <<< 24)) begin
      q = q >>> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0010, s, 8'hFF, 23'd0};
    if (e <= 0)   return {4'b0001, s, 31'd0};
    return {4'b0000, s, e[7:0], q[22:0]};
  endfunction

  // Random operand biased toward interesting classes and exponent extremes.
  function automatic logic [31:0] randOperand();
    int          k;
    logic [31:0] r;
    k = $urandom_range(0, 15);
    r = $urandom();
    case (k)
      0:       return {r[31], 31'd0};
      1:       return {r[31], 8'h00, r[22:1], 1'b1};
      2:       return {r[31], 8'hFF, 23'd0};
      3:       return {r[31], 8'hFF, r[22:1], 1'b1};
      4:       return {r[31], 8'(240 + $urandom_range(0, 14)), r[22:0]};
      5:       return {r[31], 8'($urandom_range(1, 15)), r[22:0]};
      default: return {r[31], 8'($urandom_range(100, 154)), r[22:0]};
    endcase
  endfunction

  // Issue one divide and wait (bounded) for done; lat is -1 on timeout.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] gotM, output logic [3:0] gotF, output int lat);
    @(negedge clk);
    x     = a;
    y     = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    gotM = m;
    gotF = flags;
  endtask

  logic [31:0] dirX [12] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                             32'h00000000, 32'h7F7FFFFF, 32'h00800000, 32'h7F800000,
                             32'h3F800000, 32'h7FC00001, 32'h7F800000, 32'h00000001};
  logic [31:0] dirY [12] = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h00000000,
                             32'h00000000, 32'h3E800000, 32'h41000000, 32'hBF800000,
                             32'hFF800000, 32'h3F800000, 32'h7F800000, 32'h3F800000};
  logic [31:0] dirM [12] = '{32'h40400000, 32'h3EAAAAAB, 32'hC0000000, 32'h7F800000,
                             32'h7FC00000, 32'h7F800000, 32'h00000000, 32'hFF800000,
                             32'h80000000, 32'h7FC00000, 32'h7FC00000, 32'h00000000};
  logic [3:0]  dirF [12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100,
                             4'b1000, 4'b0010, 4'b0001, 4'b0000,
                             4'b0000, 4'b1000, 4'b1000, 4'b0000};

  // Main sequence: reset, directed, random, busy/reset behaviour, back-to-back.
  initial begin
    logic [31:0] a, b, gotM, capM;
    logic [3:0]  gotF, capF;
    logic [35:0] expR;
    logic [35:0] expQ [$];
    int          lat, doneCount, doneEdge, got, sinceLast;

    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    start = 1'b0;
    x     = '0;
    y     = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_m", m, 32'd0);
    checkOutput("reset_flags", {28'd0, flags}, 32'd0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(dirX[i], dirY[i], gotM, gotF, lat);
      checkOutput($sformatf("dir%0d_latency", i), 32'(lat), 32'd28);
      checkOutput($sformatf("dir%0d_m", i), gotM, dirM[i]);
      checkOutput($sformatf("dir%0d_flags", i), {28'd0, gotF}, {28'd0, dirF[i]});
    end

    for (int i = 0; i < 40; i++) begin
      a    = randOperand();
      b    = randOperand();
      expR = refDiv(a, b);
      applyStimulus(a, b, gotM, gotF, lat);
      checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'd28);
      checkOutput($sformatf("rand%0d_m %h/%h", i, a, b), gotM, expR[31:0]);
      checkOutput($sformatf("rand%0d_flags", i), {28'd0, gotF}, {28'd0, expR[35:32]});
    end

    // Start while busy must be ignored.
    a    = 32'h40A00000;
    b    = 32'h40000000;
    expR = refDiv(a, b);
    @(negedge clk);
    x     = a;
    y     = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    x = 32'h3F800000;
    y = 32'h40400000;
    doneCount = 0;
    doneEdge  = -1;
    capM      = '0;
    capF      = '0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 6) start = 1'b1;
      @(posedge clk);
      #1;
      if (i == 6) begin
        checkOutput("busy_high", {31'd0, busy}, 32'd1);
        start = 1'b0;
      end
      if (done) begin
        doneCount++;
        if (doneEdge < 0) begin
          doneEdge = i;
          capM     = m;
          capF     = flags;
        end
      end
    end
    checkOutput("ignore_done_count", 32'(doneCount), 32'd1);
    checkOutput("ignore_done_edge", 32'(doneEdge), 32'd28);
    checkOutput("ignore_m", capM, expR[31:0]);
    checkOutput("ignore_flags", {28'd0, capF}, {28'd0, expR[35:32]});

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    x     = 32'h40400000;
    y     = 32'h3F800000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_m", m, 32'd0);
    checkOutput("midreset_flags", {28'd0, flags}, 32'd0);
    @(negedge clk) reset = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("midreset_no_done", 32'(doneCount), 32'd0);

    // Start held high: one result every 29 edges.
    @(negedge clk);
    a = randOperand();
    b = randOperand();
    x = a;
    y = b;
    expQ.push_back(refDiv(a, b));
    start     = 1'b1;
    got       = 0;
    sinceLast = 0;
    for (int i = 0; (i < 400) && (got < 8); i++) begin
      @(posedge clk);
      #1;
      sinceLast++;
      if (done) begin
        expR = expQ.pop_front();
        checkOutput($sformatf("b2b%0d_gap", got), 32'(sinceLast), 32'd29);
        checkOutput($sformatf("b2b%0d_m", got), m, expR[31:0]);
        checkOutput($sformatf("b2b%0d_flags", got), {28'd0, flags}, {28'd0, expR[35:32]});
        got++;
        sinceLast = 0;
        a = randOperand();
        b = randOperand();
        x = a;
        y = b;
        expQ.push_back(refDiv(a, b));
      end
    end
    checkOutput("b2b_count", 32'(got), 32'd8);
    @(negedge clk) start = 1'b0;
    repeat (35) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fp_div_32.md
FP_DIV_32 -- requirements
Module: fp_div_32

Interface
REQ-001 The module SHALL have parameter LATENCY, default 28, meaning the number of rising edges from the start-sampling edge to the edge that asserts done; the value is fixed and SHALL NOT be overridden.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit, which requests a divide; it is sampled only in IDLE.
REQ-005 The module SHALL have port x, input, 32 bits, the IEEE-754 single-precision dividend; it is captured on the accepted start edge.
REQ-006 The module SHALL have port y, input, 32 bits, the IEEE-754 single-precision divisor; it is captured on the accepted start edge.
REQ-007 The module SHALL have port busy, output, 1 bit, which is high in every state other than IDLE.
REQ-008 The module SHALL have port done, output, 1 bit, a single-cycle pulse that marks m and flags as valid.
REQ-009 The module SHALL have port m, output, 32 bits, the registered quotient x/y; it holds its value until the next done.
REQ-010 The module SHALL have port flags, output, 4 bits, ordered {invalid, div_by_zero, overflow, underflow}; it is registered together with m.

Function
REQ-011 The state machine SHALL have the states IDLE, UNPACK, DIVIDE, ROUND.
REQ-012 In IDLE with start=1, the edge SHALL capture x and y and move to UNPACK; start seen in any other state SHALL be ignored.
REQ-013 UNPACK SHALL take one cycle: split sign, exponent and mantissa, add the hidden 1, classify each operand as zero, denormal, inf or NaN, then move to DIVIDE.
REQ-014 DIVIDE SHALL be restoring division, one quotient bit per cycle, for exactly 26 cycles, giving 26 quotient bits; sticky SHALL be set when the final remainder is nonzero; the state then moves to ROUND.
REQ-015 ROUND SHALL take one cycle: it normalizes, rounds, writes m and flags, pulses done, and returns to IDLE.
REQ-016 Latency SHALL be fixed: done asserts on the 28th rising edge after the start-sampling edge, for every operand class, including special cases.
REQ-017 A new start in the cycle done is high SHALL be accepted, so back-to-back operations run every 29 edges.
REQ-018 Sign SHALL be x[31] XOR y[31] for every result, including zero and inf; NaN is the only exception.
REQ-019 The exponent SHALL be computed as ex - ey + 127 in at least 10-bit signed arithmetic.
REQ-020 When mx < my, the quotient SHALL be left-shifted by 1 and the exponent decremented by 1.
REQ-021 Rounding SHALL be round-to-nearest-even using guard and sticky.
REQ-022 If rounding carries the mantissa to 2.0, the mantissa SHALL be renormalized and the exponent incremented.
REQ-023 If the final exponent is >= 255, m SHALL be signed inf and overflow SHALL be set.
REQ-024 If the final exponent is <= 0, m SHALL be signed zero and underflow SHALL be set; no denormal outputs are produced.
REQ-025 Denormal inputs SHALL be treated as zero of the same sign.
REQ-026 If either input is NaN, or the operation is 0/0 or inf/inf, m SHALL be 0x7FC00000 and invalid SHALL be set.
REQ-027 Finite nonzero / 0 SHALL give signed inf with div_by_zero set.
REQ-028 inf / finite SHALL give signed inf with no flag set.
REQ-029 finite / inf and 0 / nonzero SHALL give signed zero with no flag set.
REQ-030 Special-case results SHALL still pass through DIVIDE; the iteration result is discarded and the latency is unchanged.

Reset
REQ-031 reset=1 SHALL at once force IDLE, busy=0, done=0, m=0x00000000 and flags=0000, and clear all internal registers.
REQ-032 Reset asserted mid-operation SHALL abort the operation; no done SHALL follow for that operation.
REQ-033 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-034 Package fp_div_pkg SHALL hold: the state enum; the constants BIAS=127, EXP_MAX=255, QNAN=0x7FC00000, DIV_ITERS=26 and LATENCY=28; and the flag bit indices.
REQ-035 One sub-module, fp_div_mant_iter, SHALL hold the 26-step restoring mantissa iterator, with start/done and quotient/sticky outputs.
REQ-036 Unpack, special-case logic and rounding SHALL stay in fp_div_32.

Verification
REQ-037 x=0x40C00000, y=0x40000000 -> m=0x40400000, flags=0000, done exactly 28 edges after start.
REQ-038 x=0x3F800000, y=0x40400000 -> m=0x3EAAAAAB (RNE round-up), flags=0000.
REQ-039 Signs and specials:
- x=0xBF800000, y=0x3F000000 -> m=0xC0000000.
- x=0x3F800000, y=0x00000000 -> m=0x7F800000, flags=0100.
- x=0x00000000, y=0x00000000 -> m=0x7FC00000, flags=1000.
REQ-040 Exponent limits:
- x=0x7F7FFFFF, y=0x3E800000 -> m=0x7F800000, flags=0010.
- x=0x00800000, y=0x41000000 -> m=0x00000000, flags=0001.
REQ-041 Busy and reset:
- Start pulsed again while busy -> ignored; exactly one done, m from the first operands.
- reset asserted at edge 10 of an operation -> busy=0 at once, no done within the following 40 edges.
REQ-042 Back-to-back: start held high continuously -> done every 29 edges; every m matches a reference model computed with round-to-nearest-even.
